regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised general-purpose register file for the processor datapath. It has two asynchronous read ports and two synchronous write ports: port A for ALU writeback and port B for load writeback. It adds same-cycle write-to-read bypass, a per-register pending (scoreboard) bit set at instruction issue, and a stall output for the operand fetch stage. It is the multi-writeback, hazard-aware successor of the 16x32 single-write register file.

Parameters:
DATA_W, 32, register width in bits
NREG, 16, number of registers
ADDR_W, 4, address width; must satisfy 2**ADDR_W >= NREG
ZERO_REG, 0, if 1 then register 0 reads as 0, ignores writes and is never marked pending

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
rs1_addr  in  ADDR_W  read port 1 address
rs2_addr  in  ADDR_W  read port 2 address
rd_data1  out  DATA_W  read port 1 data (combinational)
rd_data2  out  DATA_W  read port 2 data (combinational)
wa_en  in  1  write port A enable (ALU writeback)
wa_addr  in  ADDR_W  write port A address
wa_data  in  DATA_W  write port A data
wb_en  in  1  write port B enable (load writeback)
wb_addr  in  ADDR_W  write port B address
wb_data  in  DATA_W  write port B data
res_en  in  1  reserve destination at issue (set pending)
res_addr  in  ADDR_W  destination register being reserved
rs1_busy  out  1  rs1_addr pending after bypass
rs2_busy  out  1  rs2_addr pending after bypass
stall  out  1  rs1_busy | rs2_busy
wr_collide  out  1  sticky: both ports wrote the same address in one cycle

Behaviour:
- Reset (rst=1 at a posedge): all NREG registers <= 0, all pending bits <= 0, wr_collide <= 0. Reset overrides every write and reserve in the same cycle. After reset every rd_data is 0 and every busy/stall output is 0.
- Reads: combinational. Addresses >= NREG return 0 and busy=0.
- Bypass: if wb_en and wb_addr==rsN_addr, rd_dataN = wb_data. Otherwise, if wa_en and wa_addr==rsN_addr, rd_dataN = wa_data. Otherwise rd_dataN = the stored value. Port B has priority over port A.
- Writes: at posedge with rst=0, reg[wa_addr] <= wa_data if wa_en; reg[wb_addr] <= wb_data if wb_en. Writes to addresses >= NREG are dropped.
- Write collision: if wa_en and wb_en target the same address, port B's data is stored and wr_collide <= 1. wr_collide stays at 1 until rst.
- Pending bits: an enabled write to address X clears pending[X]. res_en sets pending[res_addr].
  - If reserve and write hit the same register in the same cycle, the reserve wins and the bit ends at 1 (a new producer has been issued).
- Busy: rsN_busy = pending[rsN_addr] & ~(a same-cycle enabled write to rsN_addr). An in-flight writeback therefore does not stall its consumer. res_en in the current cycle does not affect busy until the next cycle.
- ZERO_REG=1: reads of address 0 return 0, including under bypass. Writes to address 0 are ignored, res_addr=0 is ignored, and busy for address 0 is always 0.
- Latency: write-to-stored-read is 1 cycle; write-to-read through bypass is 0 cycles; reserve-to-busy is 1 cycle.
- No internal FSM beyond the pending vector and the sticky flag. All state is registered on clk; no latches.

Test Plan:
- Reset then read all: rst=1 for 1 cycle -> rd_data1/2=0 for addresses 0..15, stall=0, wr_collide=0.
- Write then read: wa_en, wa_addr=3, wa_data=0xDEADBEEF, rs1_addr=3 in the same cycle -> rd_data1=0xDEADBEEF combinationally, and still 0xDEADBEEF after the edge with wa_en=0.
- Scoreboard: res_en, res_addr=5 -> next cycle, rs2_addr=5 gives rs2_busy=1 and stall=1. wb_en, wb_addr=5, wb_data=0x12 -> same cycle rs2_busy=0 and rd_data2=0x12; the cycle after, pending[5]=0.
- Reserve/write race: pending[7]=1, then wa_en to 7 together with res_en to 7 -> next cycle rs1_addr=7 gives rs1_busy=1 and the stored value equals wa_data.
- Collision: wa_en and wb_en both to 9, wa_data=0x1, wb_data=0x2 -> same-cycle read of 9 is 0x2, stored value is 0x2, wr_collide=1 and remains 1 until rst.
- ZERO_REG=1 build: write 0xFF to reg 0 and res_en to 0 -> rd_data1=0 and rs1_busy=0 both during and after the write. Separately, assert rst in the same cycle as wa_en to 4 -> reg 4 reads 0.

Source files
------------

// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, two writeback ports
// (A = ALU, B = load), same-cycle write-to-read bypass, a per-register
// pending scoreboard and a sticky write-collision flag.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int NREG     = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              wa_en,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic [DATA_W-1:0] wa_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              res_en,
    input  logic [ADDR_W-1:0] res_addr,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              stall,
    output logic              wr_collide
);

    // Register count widened by one bit so the range compare is width-clean
    // even when NREG == 2**ADDR_W.
    localparam logic [ADDR_W:0] NREG_EXT = (ADDR_W + 1)'(NREG);

    logic [DATA_W-1:0] regs_reg [NREG];
    logic [NREG-1:0]   pending_reg;
    logic              wr_collide_reg;

    // One-hot decodes of the write and reserve targets, already filtered for
    // out-of-range addresses and the hardwired zero register.
    logic [NREG-1:0]   wa_hit;
    logic [NREG-1:0]   wb_hit;
    logic [NREG-1:0]   res_hit;

    logic              wa_ok;
    logic              wb_ok;
    logic              res_ok;

    logic [ADDR_W-1:0] rs_addr [2];

    // An address names a real, writable/trackable register.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < NREG_EXT) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wa_ok  = wa_en  && addr_ok(wa_addr);
    assign wb_ok  = wb_en  && addr_ok(wb_addr);
    assign res_ok = res_en && addr_ok(res_addr);

    assign rs_addr[0] = rs1_addr;
    assign rs_addr[1] = rs2_addr;

    genvar gi;

    generate
        for (gi = 0; gi < NREG; gi++) begin : g_dec
            assign wa_hit[gi]  = wa_ok  && (wa_addr  == ADDR_W'(gi));
            assign wb_hit[gi]  = wb_ok  && (wb_addr  == ADDR_W'(gi));
            assign res_hit[gi] = res_ok && (res_addr == ADDR_W'(gi));
        end
    endgenerate

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic              rs_ok;
            logic              hit_a;
            logic              hit_b;
            logic [DATA_W-1:0] rd_val;
            logic              busy;

            assign rs_ok = addr_ok(rs_addr[gi]);
            assign hit_a = wa_ok && (wa_addr == rs_addr[gi]);
            assign hit_b = wb_ok && (wb_addr == rs_addr[gi]);

            // Read mux: load writeback beats ALU writeback beats stored value.
            always_comb begin
                rd_val = '0;
                busy   = 1'b0;
                if (rs_ok) begin
                    if (hit_b) begin
                        rd_val = wb_data;
                    end else if (hit_a) begin
                        rd_val = wa_data;
                    end else begin
                        rd_val = regs_reg[rs_addr[gi]];
                    end
                    // A writeback landing this cycle satisfies the consumer.
                    busy = pending_reg[rs_addr[gi]] && !(hit_a || hit_b);
                end
            end
        end
    endgenerate

    assign rd_data1   = g_rd[0].rd_val;
    assign rd_data2   = g_rd[1].rd_val;
    assign rs1_busy   = g_rd[0].busy;
    assign rs2_busy   = g_rd[1].busy;
    assign stall      = g_rd[0].busy | g_rd[1].busy;
    assign wr_collide = wr_collide_reg;

    // Register array, scoreboard and collision flag; reset overrides all writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
            end
            pending_reg    <= '0;
            wr_collide_reg <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wb_hit[i]) begin
                    regs_reg[i] <= wb_data;
                end else if (wa_hit[i]) begin
                    regs_reg[i] <= wa_data;
                end
            end
            // Writeback retires the producer; a same-cycle reserve re-arms it.
            pending_reg <= (pending_reg & ~(wa_hit | wb_hit)) | res_hit;
            if (wa_en && wb_en && (wa_addr == wb_addr)) begin
                wr_collide_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one default build and one ZERO_REG=1 build
// driven by the same stimulus.
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic [3:0]  rs1_addr;
    logic [3:0]  rs2_addr;
    logic        wa_en;
    logic [3:0]  wa_addr;
    logic [31:0] wa_data;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        res_en;
    logic [3:0]  res_addr;

    logic [31:0] rd_data1, rd_data2;
    logic        rs1_busy, rs2_busy, stall, wr_collide;
    logic [31:0] rd_data1_z, rd_data2_z;
    logic        rs1_busy_z, rs2_busy_z, stall_z, wr_collide_z;

    int checks = 0;
    int errors = 0;

    regfile_sb #(.DATA_W(32), .NREG(16), .ADDR_W(4), .ZERO_REG(0)) u_dut (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .res_en(res_en), .res_addr(res_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .stall(stall), .wr_collide(wr_collide)
    );

    regfile_sb #(.DATA_W(32), .NREG(16), .ADDR_W(4), .ZERO_REG(1)) u_dut_z (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd_data1(rd_data1_z), .rd_data2(rd_data2_z),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .res_en(res_en), .res_addr(res_addr),
        .rs1_busy(rs1_busy_z), .rs2_busy(rs2_busy_z),
        .stall(stall_z), .wr_collide(wr_collide_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("[%0t] check %s observed %h expected %h", $time, tag, obs, exp);
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wa_en = 1'b0; wb_en = 1'b0; res_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rs1_addr = '0; rs2_addr = '0;
        wa_en = 1'b0; wa_addr = '0; wa_data = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        res_en = 1'b0; res_addr = '0;

        // Reset, then read every register on both ports.
        tick();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rs1_addr = 4'(i);
            rs2_addr = 4'(15 - i);
            #1;
            check($sformatf("reset_rd1_r%0d", i), rd_data1, 32'h0);
            check($sformatf("reset_rd2_r%0d", 15 - i), rd_data2, 32'h0);
            check($sformatf("reset_stall_%0d", i), 32'(stall), 32'h0);
            check($sformatf("reset_stall_z_%0d", i), 32'(stall_z), 32'h0);
        end
        check("reset_collide", 32'(wr_collide), 32'h0);

        // Port A write with same-cycle bypass, then stored read.
        wa_en = 1'b1; wa_addr = 4'd3; wa_data = 32'hDEADBEEF; rs1_addr = 4'd3;
        #1;
        check("wa_bypass_r3", rd_data1, 32'hDEADBEEF);
        tick();
        idle();
        #1;
        check("wa_stored_r3", rd_data1, 32'hDEADBEEF);

        // Reserve r5: busy only from the next cycle.
        res_en = 1'b1; res_addr = 4'd5; rs2_addr = 4'd5;
        #1;
        check("res_same_cycle_busy", 32'(rs2_busy), 32'h0);
        tick();
        idle();
        #1;
        check("res_next_busy", 32'(rs2_busy), 32'h1);
        check("res_next_stall", 32'(stall), 32'h1);
        // Load writeback to r5 releases the consumer in the same cycle.
        wb_en = 1'b1; wb_addr = 4'd5; wb_data = 32'h12;
        #1;
        check("wb_inflight_busy", 32'(rs2_busy), 32'h0);
        check("wb_inflight_stall", 32'(stall), 32'h0);
        check("wb_bypass_r5", rd_data2, 32'h12);
        tick();
        idle();
        #1;
        check("wb_after_busy", 32'(rs2_busy), 32'h0);
        check("wb_stored_r5", rd_data2, 32'h12);

        // Reserve/write race on r7: reserve wins, data still stored.
        res_en = 1'b1; res_addr = 4'd7; rs1_addr = 4'd7;
        tick();
        idle();
        #1;
        check("race_pre_busy", 32'(rs1_busy), 32'h1);
        wa_en = 1'b1; wa_addr = 4'd7; wa_data = 32'hCAFE0007;
        res_en = 1'b1; res_addr = 4'd7;
        #1;
        check("race_inflight_busy", 32'(rs1_busy), 32'h0);
        check("race_bypass_r7", rd_data1, 32'hCAFE0007);
        tick();
        idle();
        #1;
        check("race_after_busy", 32'(rs1_busy), 32'h1);
        check("race_stored_r7", rd_data1, 32'hCAFE0007);
        check("race_no_collide", 32'(wr_collide), 32'h0);

        // Collision on r9: port B wins on bypass and storage, flag is sticky.
        wa_en = 1'b1; wa_addr = 4'd9; wa_data = 32'h1;
        wb_en = 1'b1; wb_addr = 4'd9; wb_data = 32'h2;
        rs1_addr = 4'd9;
        #1;
        check("coll_bypass_r9", rd_data1, 32'h2);
        check("coll_flag_before_edge", 32'(wr_collide), 32'h0);
        tick();
        idle();
        #1;
        check("coll_stored_r9", rd_data1, 32'h2);
        check("coll_flag_set", 32'(wr_collide), 32'h1);
        wa_en = 1'b1; wa_addr = 4'd10; wa_data = 32'hA;
        wb_en = 1'b1; wb_addr = 4'd11; wb_data = 32'hB;
        tick();
        idle();
        tick();
        check("coll_flag_sticky", 32'(wr_collide), 32'h1);
        rs2_addr = 4'd11;
        #1;
        check("dual_write_r11", rd_data2, 32'hB);

        // Writes/reserve to r0: suppressed in the ZERO_REG build only.
        wa_en = 1'b1; wa_addr = 4'd0; wa_data = 32'hFF;
        res_en = 1'b1; res_addr = 4'd0; rs1_addr = 4'd0; rs2_addr = 4'd5;
        #1;
        check("zero_bypass_rd1_z", rd_data1_z, 32'h0);
        check("zero_inflight_busy_z", 32'(rs1_busy_z), 32'h0);
        check("r0_bypass_default", rd_data1, 32'hFF);
        tick();
        idle();
        #1;
        check("zero_stored_rd1_z", rd_data1_z, 32'h0);
        check("zero_after_busy_z", 32'(rs1_busy_z), 32'h0);
        check("zero_after_stall_z", 32'(stall_z), 32'h0);
        check("r0_stored_default", rd_data1, 32'hFF);
        check("r0_busy_default", 32'(rs1_busy), 32'h1);

        // Reset in the same cycle as a write to r4: reset wins.
        rst = 1'b1;
        wa_en = 1'b1; wa_addr = 4'd4; wa_data = 32'h44;
        tick();
        rst = 1'b0;
        idle();
        rs1_addr = 4'd4; rs2_addr = 4'd0;
        #1;
        check("rst_wins_r4", rd_data1, 32'h0);
        check("rst_wins_r4_z", rd_data1_z, 32'h0);
        check("rst_clears_pending", 32'(stall), 32'h0);
        check("rst_clears_collide", 32'(wr_collide), 32'h0);
        check("rst_clears_r0", rd_data2, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
